// File: rtl/data_mem_responder.sv
// data_mem_responder: memory-side end of the core <-> data-memory handshake.
// Accepts one LW/LBU/SW/SB request at a time from the core and returns read
// responses after a fixed latency. Holds a byte-addressed, word-organised RAM.
//
// Ports:
//   clk          clock, all state on rising edge
//   n_reset      synchronous active-low reset
//   from_core_i  request {write_data, valid, wen, byte_not_word, yumi}
//   addr_i       byte address, qualified by from_core_i.valid
//   to_core_o    response {read_data, valid, yumi}
//   busy_o       high whenever the FSM is not idle

package data_mem_pkg;

  typedef struct packed {
    logic [31:0] write_data;
    logic        valid;
    logic        wen;
    logic        byte_not_word;
    logic        yumi;
  } mem_in_s;

  typedef struct packed {
    logic [31:0] read_data;
    logic        valid;
    logic        yumi;
  } mem_out_s;

endpackage

module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int unsigned ADDR_W_P = 12,
  parameter int unsigned RD_LAT_P = 1
) (
  input  logic                clk,
  input  logic                n_reset,
  input  mem_in_s             from_core_i,
  input  logic [ADDR_W_P-1:0] addr_i,
  output mem_out_s            to_core_o,
  output logic                busy_o
);

  localparam int unsigned Words = 2 ** (ADDR_W_P - 2);
  localparam int unsigned CntW  = $clog2(RD_LAT_P + 1);
  // WAIT spends LatLoad+1 cycles, RESP is entered at accept + RD_LAT_P.
  localparam logic [CntW-1:0] LatLoad = CntW'((RD_LAT_P >= 2) ? RD_LAT_P - 2 : 0);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [31:0]         rdata_q;
  logic [31:0]         mem_q [Words];

  logic                accept;
  logic [ADDR_W_P-3:0] word_idx;
  logic [1:0]          lane;
  logic [31:0]         rd_word;
  logic [7:0]          rd_byte;

  assign word_idx = addr_i[ADDR_W_P-1:2];
  assign lane     = addr_i[1:0];

  // Including n_reset keeps a request from being accepted (or written) in reset.
  assign accept = (state_q == StIdle) & from_core_i.valid & n_reset;

  always_comb begin
    rd_word = mem_q[word_idx];
    rd_byte = rd_word[{lane, 3'b000} +: 8];
  end

  // RAM is deliberately not reset.
  always_ff @(posedge clk) begin
    if (accept && from_core_i.wen) begin
      if (from_core_i.byte_not_word) begin
        mem_q[word_idx][{lane, 3'b000} +: 8] <= from_core_i.write_data[7:0];
      end else begin
        mem_q[word_idx] <= from_core_i.write_data;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept && !from_core_i.wen) begin
          if (RD_LAT_P == 1) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = LatLoad;
          end
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        if (from_core_i.yumi) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // read_data holds its last value until the next read is accepted.
      if (accept && !from_core_i.wen) begin
        rdata_q <= from_core_i.byte_not_word ? {24'h0, rd_byte} : rd_word;
      end
    end
  end

  always_comb begin
    to_core_o           = '0;
    to_core_o.read_data = rdata_q;
    to_core_o.valid     = (state_q == StResp);
    to_core_o.yumi      = accept;
    busy_o              = (state_q != StIdle);
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (read latency 1 and 3) driven by
// directed steps; read results are predicted from a local RAM model and
// queued at accept time, then popped when the response becomes valid.
module tb_data_mem_responder;
  import data_mem_pkg::*;

  logic        clk;
  logic        n_reset;
  mem_in_s     from_core [2];
  logic [11:0] addr      [2];
  mem_out_s    to_core   [2];
  logic        busy      [2];

  int unsigned n_assert;
  int unsigned n_fail;
  logic [31:0] model [int unsigned];
  logic [31:0] exp_q [$];

  data_mem_responder #(.ADDR_W_P(12), .RD_LAT_P(1)) dut0 (
    .clk         (clk),
    .n_reset     (n_reset),
    .from_core_i (from_core[0]),
    .addr_i      (addr[0]),
    .to_core_o   (to_core[0]),
    .busy_o      (busy[0])
  );

  data_mem_responder #(.ADDR_W_P(12), .RD_LAT_P(3)) dut1 (
    .clk         (clk),
    .n_reset     (n_reset),
    .from_core_i (from_core[1]),
    .addr_i      (addr[1]),
    .to_core_o   (to_core[1]),
    .busy_o      (busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_read(input logic [11:0] a, input logic bnw);
    logic [31:0] w;
    w = model.exists(int'(a[11:2])) ? model[int'(a[11:2])] : 32'h0;
    if (bnw) return {24'h0, 8'(w >> {a[1:0], 3'b000})};
    return w;
  endfunction

  task automatic model_write(input logic [11:0] a, input logic bnw, input logic [31:0] wd);
    logic [31:0] w;
    w = model.exists(int'(a[11:2])) ? model[int'(a[11:2])] : 32'h0;
    if (bnw) w[{a[1:0], 3'b000} +: 8] = wd[7:0];
    else w = wd;
    model[int'(a[11:2])] = w;
  endtask

  // Drive a write in the next cycle and check it is accepted; leaves it driven.
  task automatic do_write(input int d, input logic bnw, input logic [11:0] a,
                          input logic [31:0] wd);
    cyc();
    from_core[d] = '0;
    from_core[d].valid = 1'b1;
    from_core[d].wen = 1'b1;
    from_core[d].byte_not_word = bnw;
    from_core[d].write_data = wd;
    addr[d] = a;
    #1;
    chk("wr_yumi", 32'(to_core[d].yumi), 32'd1);
    chk("wr_no_valid", 32'(to_core[d].valid), 32'd0);
    model_write(a, bnw, wd);
  endtask

  // Accept a read in the next cycle and queue its predicted data.
  task automatic read_accept(input int d, input logic bnw, input logic [11:0] a);
    cyc();
    from_core[d] = '0;
    from_core[d].valid = 1'b1;
    from_core[d].byte_not_word = bnw;
    addr[d] = a;
    #1;
    chk("rd_yumi", 32'(to_core[d].yumi), 32'd1);
    exp_q.push_back(model_read(a, bnw));
  endtask

  // Wait for the response, check latency/data, yumi it at once, check return to idle.
  task automatic read_finish(input int d, input int lat);
    logic seen;
    logic [31:0] e;
    seen = 1'b0;
    cyc();
    from_core[d].valid = 1'b0;
    #1;
    for (int k = 1; k <= 20; k++) begin
      if (to_core[d].valid) begin
        seen = 1'b1;
        chk("rd_latency", 32'(k), 32'(lat));
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        chk("rd_data", to_core[d].read_data, e);
        from_core[d].yumi = 1'b1;
        #1;
        chk("resp_no_accept", 32'(to_core[d].yumi), 32'd0);
        break;
      end
      chk("rd_busy_wait", 32'(busy[d]), 32'd1);
      cyc();
    end
    if (!seen) chk("rd_timeout", 32'd0, 32'd1);
    cyc();
    from_core[d] = '0;
    #1;
    chk("rd_valid_drop", 32'(to_core[d].valid), 32'd0);
    chk("rd_idle", 32'(busy[d]), 32'd0);
  endtask

  task automatic do_read(input int d, input logic bnw, input logic [11:0] a, input int lat);
    read_accept(d, bnw, a);
    read_finish(d, lat);
  endtask

  initial begin
    logic [31:0] held;
    n_assert = 0;
    n_fail = 0;
    for (int d = 0; d < 2; d++) begin
      from_core[d] = '0;
      addr[d] = '0;
    end

    // Reset held with a valid read pending on both instances.
    n_reset = 1'b0;
    from_core[0].valid = 1'b1;
    from_core[1].valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      #1;
      for (int d = 0; d < 2; d++) begin
        chk("rst_yumi", 32'(to_core[d].yumi), 32'd0);
        chk("rst_valid", 32'(to_core[d].valid), 32'd0);
        chk("rst_busy", 32'(busy[d]), 32'd0);
        chk("rst_rdata", to_core[d].read_data, 32'd0);
      end
    end
    from_core[0] = '0;
    from_core[1] = '0;
    cyc();
    n_reset = 1'b1;

    // SW then back-to-back LW, latency 1.
    do_write(0, 1'b0, 12'h010, 32'hDEAD_BEEF);
    do_read(0, 1'b0, 12'h010, 1);

    // Byte write into a word, byte and word readback.
    do_write(0, 1'b0, 12'h010, 32'h1122_3344);
    do_write(0, 1'b1, 12'h013, 32'hFFFF_FFA5);
    do_read(0, 1'b1, 12'h013, 1);
    do_read(0, 1'b0, 12'h010, 1);
    do_read(0, 1'b1, 12'h011, 1);
    do_read(0, 1'b0, 12'h012, 1);  // word access ignores low address bits

    // Top word, back-to-back.
    do_write(0, 1'b0, 12'hFFC, 32'hCAFE_F00D);
    do_read(0, 1'b0, 12'hFFC, 1);
    do_read(0, 1'b0, 12'h010, 1);

    // Latency 3, response withheld while a second request waits.
    do_write(1, 1'b0, 12'h020, 32'h0BAD_CAFE);
    read_accept(1, 1'b0, 12'h020);
    cyc();
    from_core[1] = '0;
    from_core[1].valid = 1'b1;
    from_core[1].wen = 1'b1;
    from_core[1].write_data = 32'h5555_AAAA;
    addr[1] = 12'h024;
    #1;
    chk("lat3_wait1_valid", 32'(to_core[1].valid), 32'd0);
    chk("lat3_pend_yumi", 32'(to_core[1].yumi), 32'd0);
    cyc();
    #1;
    chk("lat3_wait2_valid", 32'(to_core[1].valid), 32'd0);
    chk("lat3_busy", 32'(busy[1]), 32'd1);
    cyc();
    #1;
    chk("lat3_valid_t3", 32'(to_core[1].valid), 32'd1);
    chk("lat3_data", to_core[1].read_data, exp_q.size() > 0 ? exp_q.pop_front() : 32'hx);
    held = to_core[1].read_data;
    for (int i = 0; i < 5; i++) begin
      cyc();
      #1;
      chk("lat3_hold_valid", 32'(to_core[1].valid), 32'd1);
      chk("lat3_hold_data", to_core[1].read_data, held);
      chk("lat3_hold_pend", 32'(to_core[1].yumi), 32'd0);
    end
    from_core[1].yumi = 1'b1;
    #1;
    chk("lat3_exit_pend", 32'(to_core[1].yumi), 32'd0);
    cyc();
    from_core[1].yumi = 1'b0;
    #1;
    chk("lat3_idle_valid", 32'(to_core[1].valid), 32'd0);
    chk("lat3_pend_accept", 32'(to_core[1].yumi), 32'd1);
    chk("lat3_rdata_kept", to_core[1].read_data, held);
    model_write(12'h024, 1'b0, 32'h5555_AAAA);
    do_read(1, 1'b0, 12'h024, 3);

    // Reset while a read waits: the read is dropped, RAM survives.
    read_accept(1, 1'b0, 12'h020);
    cyc();
    from_core[1] = '0;
    #1;
    chk("rst_mid_busy", 32'(busy[1]), 32'd1);
    n_reset = 1'b0;
    cyc();
    n_reset = 1'b1;
    #1;
    chk("rst_mid_idle", 32'(busy[1]), 32'd0);
    void'(exp_q.pop_front());
    for (int i = 0; i < 5; i++) begin
      chk("rst_mid_no_valid", 32'(to_core[1].valid), 32'd0);
      cyc();
    end
    do_read(1, 1'b0, 12'h020, 3);
    do_read(0, 1'b0, 12'hFFC, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
